fifo_rd_ctrl: RTL

Read-side controller for the async FIFO; sits in the read clock domain opposite the write controller and drives the dual-port RAM's combinational read port.
It synchronizes the write-domain Gray pointer, maintains the binary and Gray read pointers, and computes empty and fill level.
It presents data through a one-entry show-ahead output register with a valid/ready handshake.
Its registered Gray read pointer is returned to the write domain for full detection.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 37 +++
 rtl/fifo_rd_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary pointer conversion.
// The functions work on a 32-bit zero-extended value. Zero high bits do not change
// the result of either conversion, so callers of any width up to 32 cast in and out.
package fifo_pkg;

  localparam int unsigned FIFO_ADDRW  = 5;
  localparam int unsigned FIFO_DEPTH  = 32'd1 << FIFO_ADDRW;
  localparam int unsigned CODE_MAX_W  = 32;

  // Binary to reflected Gray code.
  function automatic logic [CODE_MAX_W-1:0] bin2gray(input logic [CODE_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary: each output bit is the XOR of all Gray bits at or above it.
  function automatic logic [CODE_MAX_W-1:0] gray2bin(input logic [CODE_MAX_W-1:0] gray);
    logic [CODE_MAX_W-1:0] bin;
    bin = gray;
    for (int unsigned i = 1; i < CODE_MAX_W; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage : fifo_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a multi-bit Gray-coded bus.
// Ports:
//   clk  - destination-domain clock
//   rst  - synchronous active-high reset, clears both stages to 0
//   d    - asynchronous input bus
//   q    - synchronized output (second stage)
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1_d, stage1_q;
  logic [WIDTH-1:0] stage2_d, stage2_q;

  // Next-state of the chain: each stage takes the one before it.
  always_comb begin
    stage1_d = d;
    stage2_d = stage1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign q = stage2_q;

endmodule : sync_2ff

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO. Synchronizes the write Gray pointer,
// keeps binary and Gray read pointers, derives empty/level, and presents data
// through a one-entry show-ahead output register with valid/ready.
// Ports:
//   rclk            - read-domain clock
//   rst             - synchronous active-high reset
//   wptr_gray_async - write pointer (Gray) from the write domain, unsynchronized
//   r_addr_ram      - RAM read address (low bits of the binary read pointer)
//   ram_dout        - RAM read data, combinational from r_addr_ram
//   rptr_gray       - registered Gray read pointer, returned to the write domain
//   rd_valid        - rd_data holds a valid word
//   rd_ready        - consumer accepts the word this cycle
//   rd_data         - output word
//   ram_empty       - no unread words left in RAM (output register excluded)
//   rd_level        - words in RAM as seen from the read domain, 0..DEPTH
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = FIFO_DEPTH,
  parameter int unsigned RD_DW    = 8,
  parameter int unsigned RD_ADDRW = FIFO_ADDRW
) (
  input  logic                rclk,
  input  logic                rst,
  input  logic [RD_ADDRW:0]   wptr_gray_async,
  output logic [RD_ADDRW-1:0] r_addr_ram,
  input  logic [RD_DW-1:0]    ram_dout,
  output logic [RD_ADDRW:0]   rptr_gray,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [RD_DW-1:0]    rd_data,
  output logic                ram_empty,
  output logic [RD_ADDRW:0]   rd_level
);

  localparam int unsigned PTR_W = RD_ADDRW + 1;

  // Geometry guard: the extra pointer bit only separates laps if DEPTH is a full power of two.
  if (DEPTH != (32'd1 << RD_ADDRW)) begin : g_depth_chk
    $error("fifo_rd_ctrl: DEPTH must equal 2**RD_ADDRW");
  end

  logic [PTR_W-1:0] wq2;
  logic [PTR_W-1:0] wbin_s;
  logic [PTR_W-1:0] rptr_bin_inc;
  logic             load;

  logic [PTR_W-1:0] rptr_bin_d,  rptr_bin_q;
  logic [PTR_W-1:0] rptr_gray_d, rptr_gray_q;
  logic             rd_valid_d,  rd_valid_q;
  logic [RD_DW-1:0] rd_data_d,   rd_data_q;

  // Write pointer brought into the read domain.
  sync_2ff #(
    .WIDTH (PTR_W)
  ) u_wptr_sync (
    .clk (rclk),
    .rst (rst),
    .d   (wptr_gray_async),
    .q   (wq2)
  );

  // Occupancy as seen here; modulo arithmetic on the lap bit hides pointer wrap.
  always_comb begin
    wbin_s    = PTR_W'(gray2bin(CODE_MAX_W'(wq2)));
    rd_level  = wbin_s - rptr_bin_q;
    ram_empty = (wq2 == rptr_gray_q);
  end

  // Output register refills whenever it is free or being drained this cycle.
  always_comb begin
    rptr_bin_inc = rptr_bin_q + PTR_W'(1);
    load         = !ram_empty && (!rd_valid_q || rd_ready);

    rptr_bin_d  = rptr_bin_q;
    rptr_gray_d = rptr_gray_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;

    if (load) begin
      rd_data_d   = ram_dout;
      rd_valid_d  = 1'b1;
      rptr_bin_d  = rptr_bin_inc;
      rptr_gray_d = PTR_W'(bin2gray(CODE_MAX_W'(rptr_bin_inc)));
    end else if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      rptr_bin_q  <= '0;
      rptr_gray_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      rptr_bin_q  <= rptr_bin_d;
      rptr_gray_q <= rptr_gray_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign r_addr_ram = rptr_bin_q[RD_ADDRW-1:0];
  assign rptr_gray  = rptr_gray_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;

endmodule : fifo_rd_ctrl
